// File: rtl/frame_min_max_tracker_pkg.sv
// Shared types and defaults for the frame min/max tracker.
package frame_min_max_tracker_pkg;
  localparam int DEF_N     = 32;
  localparam int DEF_CNT_W = 16;
  localparam logic [DEF_CNT_W-1:0] DEF_CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;
endpackage

// File: rtl/frame_min_max_tracker_cmp.sv
// Signed n-bit comparator: flags come from A-B with overflow correction, not the raw sign.
module n_bit_comparator #(
  parameter int n = 32
) (
  input  logic [n-1:0] A,
  input  logic [n-1:0] B,
  output logic         Smaller,
  output logic         Larger,
  output logic         Equal,
  output logic         S,
  output logic         Z,
  output logic         N,
  output logic         V
);
  logic [n-1:0] diff;

  assign diff = A - B;
  assign S    = diff[n-1];
  assign Z    = (diff == '0);
  // overflow only when operand signs differ and the result sign leaves A's
  assign V    = (A[n-1] != B[n-1]) && (diff[n-1] != A[n-1]);
  assign N    = S ^ V;

  assign Smaller = N;
  assign Equal   = Z;
  assign Larger  = !N && !Z;
endmodule

// File: rtl/frame_min_max_tracker.sv
// Streams a frame of signed samples, tracks min/max with first-occurrence indices, emits one result beat.
module frame_min_max_tracker
  import frame_min_max_tracker_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_min,
  output logic [N-1:0]     out_max,
  output logic [CNT_W-1:0] out_min_idx,
  output logic [CNT_W-1:0] out_max_idx,
  output logic [CNT_W-1:0] out_count,
  output logic             out_sat
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t state, state_nx;
  logic   accept;
  logic   lt_min, gt_max;
  logic [5:0] cmp_min_unused, cmp_max_unused;

  assign in_ready  = (state != ST_HOLD);
  assign out_valid = (state == ST_HOLD);
  assign accept    = in_valid && in_ready;

  n_bit_comparator #(.n(N)) u_cmp_min (
    .A(in_data), .B(out_min),
    .Smaller(lt_min), .Larger(cmp_min_unused[5]), .Equal(cmp_min_unused[4]),
    .S(cmp_min_unused[3]), .Z(cmp_min_unused[2]), .N(cmp_min_unused[1]), .V(cmp_min_unused[0])
  );

  n_bit_comparator #(.n(N)) u_cmp_max (
    .A(in_data), .B(out_max),
    .Smaller(cmp_max_unused[5]), .Larger(gt_max), .Equal(cmp_max_unused[4]),
    .S(cmp_max_unused[3]), .Z(cmp_max_unused[2]), .N(cmp_max_unused[1]), .V(cmp_max_unused[0])
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (accept) state_nx = in_last ? ST_HOLD : ST_ACCUM;
      ST_ACCUM: if (accept && in_last) state_nx = ST_HOLD;
      ST_HOLD:  if (out_ready) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_min     <= '0;
      out_max     <= '0;
      out_min_idx <= '0;
      out_max_idx <= '0;
      out_count   <= '0;
      out_sat     <= 1'b0;
    end else if (accept) begin
      if (state == ST_IDLE) begin
        out_min     <= in_data;
        out_max     <= in_data;
        out_min_idx <= '0;
        out_max_idx <= '0;
        out_count   <= CNT_W'(1);
        out_sat     <= 1'b0;
      end else begin
        // strict compares only: ties keep the earliest index
        if (lt_min) begin
          out_min     <= in_data;
          out_min_idx <= out_count;
        end
        if (gt_max) begin
          out_max     <= in_data;
          out_max_idx <= out_count;
        end
        if (out_count == CNT_MAX) out_sat   <= 1'b1;
        else                      out_count <= out_count + CNT_W'(1);
      end
    end else if (out_valid && out_ready) begin
      out_sat <= 1'b0;
    end
  end
endmodule

// File: tb/tb_frame_min_max_tracker.sv
// Directed bench: default-width tracker plus an N=8/CNT_W=3 tracker for overflow and saturation.
module tb_frame_min_max_tracker;
  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  // instance A: N=32, CNT_W=16
  logic        a_in_valid, a_in_ready, a_in_last, a_out_valid, a_out_ready, a_out_sat;
  logic [31:0] a_in_data, a_out_min, a_out_max;
  logic [15:0] a_out_min_idx, a_out_max_idx, a_out_count;

  frame_min_max_tracker #(.N(32), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_last(a_in_last),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_min(a_out_min), .out_max(a_out_max),
    .out_min_idx(a_out_min_idx), .out_max_idx(a_out_max_idx),
    .out_count(a_out_count), .out_sat(a_out_sat)
  );

  // instance B: N=8, CNT_W=3
  logic       b_in_valid, b_in_ready, b_in_last, b_out_valid, b_out_ready, b_out_sat;
  logic [7:0] b_in_data, b_out_min, b_out_max;
  logic [2:0] b_out_min_idx, b_out_max_idx, b_out_count;

  frame_min_max_tracker #(.N(8), .CNT_W(3)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_last(b_in_last),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_min(b_out_min), .out_max(b_out_max),
    .out_min_idx(b_out_min_idx), .out_max_idx(b_out_max_idx),
    .out_count(b_out_count), .out_sat(b_out_sat)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_send(input logic [31:0] d, input logic l);
    @(negedge clk);
    a_in_valid = 1'b1; a_in_data = d; a_in_last = l;
    tick();
    a_in_valid = 1'b0; a_in_last = 1'b0;
  endtask

  task automatic b_send(input logic [7:0] d, input logic l);
    @(negedge clk);
    b_in_valid = 1'b1; b_in_data = d; b_in_last = l;
    tick();
    b_in_valid = 1'b0; b_in_last = 1'b0;
  endtask

  task automatic a_ack();
    @(negedge clk);
    a_out_ready = 1'b1;
    tick();
    a_out_ready = 1'b0;
  endtask

  task automatic b_ack();
    @(negedge clk);
    b_out_ready = 1'b1;
    tick();
    b_out_ready = 1'b0;
  endtask

  task automatic a_result(input string tag, input logic [31:0] mn, input logic [31:0] mx,
                          input logic [15:0] mni, input logic [15:0] mxi, input logic [15:0] cnt);
    chk({tag, "_valid"}, 32'(a_out_valid), 32'd1);
    chk({tag, "_min"}, a_out_min, mn);
    chk({tag, "_max"}, a_out_max, mx);
    chk({tag, "_min_idx"}, 32'(a_out_min_idx), 32'(mni));
    chk({tag, "_max_idx"}, 32'(a_out_max_idx), 32'(mxi));
    chk({tag, "_count"}, 32'(a_out_count), 32'(cnt));
  endtask

  task automatic b_result(input string tag, input logic [7:0] mn, input logic [7:0] mx,
                          input logic [2:0] mni, input logic [2:0] mxi, input logic [2:0] cnt,
                          input logic sat);
    chk({tag, "_valid"}, 32'(b_out_valid), 32'd1);
    chk({tag, "_min"}, 32'(b_out_min), 32'(mn));
    chk({tag, "_max"}, 32'(b_out_max), 32'(mx));
    chk({tag, "_min_idx"}, 32'(b_out_min_idx), 32'(mni));
    chk({tag, "_max_idx"}, 32'(b_out_max_idx), 32'(mxi));
    chk({tag, "_count"}, 32'(b_out_count), 32'(cnt));
    chk({tag, "_sat"}, 32'(b_out_sat), 32'(sat));
  endtask

  initial begin
    rst_n = 1'b0;
    a_in_valid = 1'b0; a_in_data = '0; a_in_last = 1'b0; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_data = '0; b_in_last = 1'b0; b_out_ready = 1'b0;
    tick(); tick();
    @(negedge clk) rst_n = 1'b1;

    // reset state
    chk("rst_in_ready", 32'(a_in_ready), 32'd1);
    chk("rst_out_valid", 32'(a_out_valid), 32'd0);
    chk("rst_min", a_out_min, 32'd0);
    chk("rst_max", a_out_max, 32'd0);
    chk("rst_count", 32'(a_out_count), 32'd0);
    chk("rst_sat", 32'(a_out_sat), 32'd0);

    // 1: {5,-3,7,-3,7}
    a_send(32'd5, 1'b0);
    a_send(32'hFFFF_FFFD, 1'b0);
    a_send(32'd7, 1'b0);
    a_send(32'hFFFF_FFFD, 1'b0);
    chk("t1_no_early_valid", 32'(a_out_valid), 32'd0);
    a_send(32'd7, 1'b1);
    a_result("t1", 32'hFFFF_FFFD, 32'd7, 16'd1, 16'd2, 16'd5);
    chk("t1_sat", 32'(a_out_sat), 32'd0);
    chk("t1_in_ready_hold", 32'(a_in_ready), 32'd0);
    a_ack();
    chk("t1_ack_valid", 32'(a_out_valid), 32'd0);
    chk("t1_ack_ready", 32'(a_in_ready), 32'd1);

    // 2: N=8 extremes {127,-128,0}
    b_send(8'h7F, 1'b0);
    b_send(8'h80, 1'b0);
    b_send(8'h00, 1'b1);
    b_result("t2", 8'h80, 8'h7F, 3'd1, 3'd0, 3'd3, 1'b0);
    b_ack();

    // 3: single sample {-1}
    a_send(32'hFFFF_FFFF, 1'b1);
    a_result("t3", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 16'd0, 16'd0, 16'd1);
    a_ack();

    // 4: backpressure in HOLD with ignored input pulses
    a_send(32'd10, 1'b0);
    a_send(32'd20, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a_in_valid = 1'b1; a_in_data = 32'd99; a_in_last = 1'b1;
      tick();
      chk("t4_hold_in_ready", 32'(a_in_ready), 32'd0);
      chk("t4_hold_valid", 32'(a_out_valid), 32'd1);
      chk("t4_hold_min", a_out_min, 32'd10);
      chk("t4_hold_max", a_out_max, 32'd20);
      chk("t4_hold_count", 32'(a_out_count), 32'd2);
    end
    a_in_valid = 1'b0; a_in_last = 1'b0;
    a_ack();
    chk("t4_ack_ready", 32'(a_in_ready), 32'd1);
    a_send(32'hFFFF_FFFB, 1'b1);
    a_result("t4_next", 32'hFFFF_FFFB, 32'hFFFF_FFFB, 16'd0, 16'd0, 16'd1);
    a_ack();

    // 5: CNT_W=3 saturation, new extremes after saturation recorded at idx 7
    b_send(8'd3, 1'b0);
    b_send(8'd3, 1'b0);
    b_send(8'd5, 1'b0);
    b_send(8'd1, 1'b0);
    b_send(8'd2, 1'b0);
    b_send(8'd9, 1'b0);
    b_send(8'd4, 1'b0);
    b_send(8'd0, 1'b0);
    b_send(8'hF9, 1'b1);
    b_result("t5", 8'hF9, 8'd9, 3'd7, 3'd5, 3'd7, 1'b1);
    b_ack();
    chk("t5_sat_cleared", 32'(b_out_sat), 32'd0);
    b_send(8'd1, 1'b0);
    b_send(8'd2, 1'b1);
    b_result("t5_next", 8'd1, 8'd2, 3'd0, 3'd1, 3'd2, 1'b0);
    b_ack();

    // 6: reset mid-frame discards the partial frame
    a_send(32'd100, 1'b0);
    a_send(32'd200, 1'b0);
    @(negedge clk) rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t6_rst_valid", 32'(a_out_valid), 32'd0);
    chk("t6_rst_count", 32'(a_out_count), 32'd0);
    chk("t6_rst_ready", 32'(a_in_ready), 32'd1);
    tick(); tick();
    chk("t6_still_no_valid", 32'(a_out_valid), 32'd0);
    a_send(32'd4, 1'b1);
    a_result("t6_next", 32'd4, 32'd4, 16'd0, 16'd0, 16'd1);
    a_ack();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
